// File: rtl/regfile_dump_reader_if.sv
// Bank read port plus the outgoing valid/ready stream of the register dump reader.
// master = the reader, slave = register bank and stream consumer side.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_addr, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_addr, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register of a bank with a registered read port and streams each
// value out over valid/ready, one beat per register, ending with a done pulse.
module regfile_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  regfile_dump_reader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = S_READ;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SEND;
      S_SEND:    if (bus.out_ready) state_next = last_q ? S_DONE : S_READ;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Counter only moves on acceptance and on a non-final handshake, so it
  // changes exactly when READ is entered and rd_addr is otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      data_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        count <= '0;
      end else if (state == S_SEND && bus.out_ready && !last_q) begin
        count <= count + 1'b1;
      end

      if (state == S_CAPTURE) begin
        data_q <= bus.rd_data;
        addr_q <= count;
        last_q <= (count == LAST_ADDR);
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.rd_en     = (state == S_READ);
  assign bus.rd_addr   = count;
  assign bus.out_valid = (state == S_SEND);
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;
  assign busy          = (state == S_READ) || (state == S_CAPTURE) || (state == S_SEND);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: bank model with registered read port,
// stream model checked every cycle, plus literal cycle/data expectations.
module tb_regfile_dump_reader;

  localparam int N = 8;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;

  regfile_dump_reader_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_dump_reader #(.NUM_REGS(N), .DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank with a one-cycle registered read port.
  logic [15:0] bank [N];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= bank[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream model: beats must arrive in address order with the expected data,
  // hold steady while stalled, and be followed by done exactly one cycle later.
  logic [15:0] exp_data [N];
  logic [15:0] got_data [N];
  int          exp_idx = 0;
  bit          done_due = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic [2:0]  prev_addr;
  logic        prev_last;
  int          beats = 0;
  int          dones = 0;
  int          rd_pulses = 0;
  int          last_done_cyc = 0;
  int          ready_mode = 0;
  int          tcnt = 0;

  task automatic monitor_step();
    if (!reset) begin
      exp_idx    = 0;
      done_due   = 0;
      prev_stall = 0;
      return;
    end
    check("done_timing", done, done_due);
    if (done) begin
      dones++;
      last_done_cyc = cyc;
    end
    done_due = 0;
    if (prev_stall) begin
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_data", bus.out_data, prev_data);
      check("stall_addr", bus.out_addr, prev_addr);
      check("stall_last", bus.out_last, prev_last);
    end
    if (bus.out_valid) begin
      check("beat_addr", bus.out_addr, exp_idx);
      check("beat_data", bus.out_data, exp_data[exp_idx]);
      check("beat_last", bus.out_last, exp_idx == N - 1);
      got_data[bus.out_addr] = bus.out_data;
      if (bus.out_ready) begin
        beats++;
        if (exp_idx == N - 1) begin
          done_due = 1;
          exp_idx  = 0;
        end else begin
          exp_idx++;
        end
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_addr  = bus.out_addr;
    prev_last  = bus.out_last;
    if (bus.rd_en) rd_pulses++;
  endtask

  // One cycle: ready is chosen before sampling so the model sees what the next edge sees.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = (tcnt % 4 == 0);
        tcnt++;
      end
      2: bus.out_ready = !(bus.out_valid && bus.out_addr == 3'd4);
      default: bus.out_ready = 1'b0;
    endcase
    monitor_step();
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic load_default_bank();
    for (int i = 0; i < N; i++) begin
      bank[i]     = 16'h1000 + 16'(i);
      exp_data[i] = 16'h1000 + 16'(i);
    end
  endtask

  int c0, b0, d0, r0, d1;
  bit found;

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    bus.out_ready = 1'b0;
    load_default_bank();
    for (int i = 0; i < N; i++) got_data[i] = 16'h0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_rd_addr", bus.rd_addr, 3'd0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0);
    check("rst_out_last", bus.out_last, 1'b0);
    reset = 1'b1;
    tick();

    // Plain dump, ready held high: busy cycles 1..24, done at 25
    ready_mode = 0;
    b0 = beats; d0 = dones;
    start = 1'b1;
    c0 = cyc;
    for (int r = 1; r <= 27; r++) begin
      tick();
      if (r == 1) start = 1'b0;
      check("t1_busy", busy, (r >= 1 && r <= 24));
      check("t1_done", done, (r == 25));
    end
    check("t1_beats", beats - b0, 8);
    check("t1_dones", dones - d0, 1);
    check("t1_done_cycle", last_done_cyc - c0, 25);
    check("t1_beat0", got_data[0], 16'h1000);
    check("t1_beat7", got_data[7], 16'h1007);

    // Consumer ready 1 cycle high / 3 low
    ready_mode = 1; tcnt = 0;
    b0 = beats; d0 = dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    repeat (3) tick();
    check("t2_beats", beats - b0, 8);
    check("t2_dones", dones - d0, 1);

    // start re-pulsed at cycles 2, 10, 20 is ignored
    ready_mode = 0;
    b0 = beats; d0 = dones;
    start = 1'b1;
    c0 = cyc;
    for (int r = 1; r <= 30; r++) begin
      tick();
      start = (r == 2 || r == 10 || r == 20);
    end
    check("t3_beats", beats - b0, 8);
    check("t3_dones", dones - d0, 1);
    check("t3_idle", busy, 1'b0);

    // Async reset while beat 4 is stalled
    ready_mode = 2;
    d0 = dones;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = bus.out_valid && (bus.out_addr == 3'd4);
    end
    check("t4_reached_beat4", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t4_valid_drop", bus.out_valid, 1'b0);
    check("t4_busy_drop", busy, 1'b0);
    check("t4_rd_en_drop", bus.rd_en, 1'b0);
    check("t4_addr_clr", bus.rd_addr, 3'd0);
    check("t4_last_clr", bus.out_last, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t4_no_done", done, 1'b0);
      check("t4_no_busy", busy, 1'b0);
    end
    check("t4_dones", dones - d0, 0);
    b0 = beats;
    got_data[0] = 16'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60);
    check("t4_redump_beats", beats - b0, 8);
    check("t4_redump_beat0", got_data[0], 16'h1000);

    // Bank write to reg 5 before its READ cycle (16)
    tick();
    exp_data[5] = 16'hBEEF;
    start = 1'b1;
    for (int r = 1; r <= 27; r++) begin
      tick();
      if (r == 1) start = 1'b0;
      if (r == 10) bank[5] = 16'hBEEF;
    end
    check("t5_early_write", got_data[5], 16'hBEEF);

    // Bank write to reg 5 after its READ cycle
    bank[5]     = 16'h1005;
    exp_data[5] = 16'h1005;
    start = 1'b1;
    for (int r = 1; r <= 27; r++) begin
      tick();
      if (r == 1) start = 1'b0;
      if (r == 20) bank[5] = 16'h5A5A;
    end
    check("t5_late_write", got_data[5], 16'h1005);
    check("t5_beat4", got_data[4], 16'h1004);

    // start held high: back-to-back dumps, one DONE cycle between
    load_default_bank();
    tick();
    d0 = dones; r0 = rd_pulses; b0 = beats;
    start = 1'b1;
    wait_done(100);
    d1 = last_done_cyc;
    wait_done(100);
    start = 1'b0;
    check("t6_period", last_done_cyc - d1, 26);
    repeat (5) tick();
    check("t6_dones", dones - d0, 2);
    check("t6_rd_pulses", rd_pulses - r0, 16);
    check("t6_beats", beats - b0, 16);
    check("t6_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the team's 16-bit register bank.
- Sequentially reads every register through the bank's read port and streams each value out over a valid/ready handshake.
- Used for debug dump, context save and test readout, without stalling the datapath.
- Assumes the bank has a registered read port: one-cycle latency from rd_en/rd_addr to rd_data.

Parameters:
- NUM_REGS, 8, number of registers dumped (2..2**ADDR_W).
- DATA_W, 16, register width.
- ADDR_W, 3, register address width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- rd_en  output  1  read strobe to register bank.
- rd_addr  output  ADDR_W  register address for read.
- rd_data  input  DATA_W  bank read data, valid the cycle after rd_en.
- out_data  output  DATA_W  streamed register value.
- out_addr  output  ADDR_W  index of register on out_data.
- out_valid  output  1  out_data/out_addr/out_last valid.
- out_ready  input  1  consumer accepts beat when out_valid & out_ready.
- out_last  output  1  high with the final beat (addr NUM_REGS-1).
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after last beat accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, address counter 0. Takes effect immediately, including mid-dump. Any partial dump is abandoned: no done pulse and no further beats.
- States:
  - IDLE: busy=0. On start=1: go to READ, counter=0, busy=1 next cycle.
  - READ: drive rd_en=1, rd_addr=counter for exactly one cycle, then go to CAPTURE.
  - CAPTURE: register rd_data into out_data and counter into out_addr; set out_valid=1. out_last=1 iff counter==NUM_REGS-1. Go to SEND.
  - SEND: hold out_data/out_addr/out_last/out_valid stable until out_ready=1. On handshake, clear out_valid next cycle. If out_last, go to DONE. Otherwise counter+1 and go to READ.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Latency:
  - start to first out_valid: 3 cycles (IDLE->READ->CAPTURE->SEND).
  - Per beat with out_ready held high: 3 cycles (READ, CAPTURE, SEND handshake).
  - Full dump with ready held high: 3*NUM_REGS cycles from start to last handshake, plus 1 cycle for done.
- rd_en is high only in READ. rd_addr holds its last value otherwise (it is 0 after reset).
- out_valid is never deasserted without a handshake. Data is not allowed to change while out_valid=1 and out_ready=0.
- start while busy (READ/CAPTURE/SEND/DONE) is ignored; no queuing.
- start asserted in the same cycle done is high is ignored (state is DONE). It is accepted the following cycle if still high.
- out_ready high while out_valid=0 has no effect.
- Counter wraps only by returning to 0 on a new start; it never exceeds NUM_REGS-1.
- Register contents changing during a dump: each beat reflects the bank value at that register's READ cycle. No snapshot coherency is provided.

Test Plan:
- Reset, then start pulse with out_ready=1, bank holding reg[i]=16'h1000+i -> beats addr 0..7, data 16'h1000..16'h1007. out_last only on addr 7. done pulses at cycle 25 after start; busy high cycles 1..24.
- Same dump with out_ready toggling 1 cycle high / 3 low -> identical 8 beats. out_data/out_addr stable throughout each stall. No beat lost or duplicated.
- start re-pulsed at cycles 2, 10 and 20 during a dump -> ignored: exactly 8 beats, single done.
- reset driven to 0 asynchronously mid-SEND of beat 4 -> out_valid, busy, rd_en drop immediately with no clock edge. No done pulse. A new start then dumps from addr 0.
- Bank write of reg[5]=16'hBEEF before that register's READ cycle -> beat 5 carries 16'hBEEF. A write after its READ cycle -> beat 5 carries the old value.
- start held high continuously -> dumps repeat back-to-back, with one idle DONE cycle and re-acceptance the next cycle. rd_en pulses once per register.
